// File: rtl/snake_pkg.sv
// Shared constants, state codes and direction helpers for the snake motion engine.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam int unsigned GRID_W_DEF   = 100;
    localparam int unsigned GRID_H_DEF   = 75;
    localparam int unsigned POS_BITS_DEF = 13;
    localparam int unsigned MAX_LEN_DEF  = 64;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RUN   = 3'd1;
    localparam state_t ST_CHECK = 3'd2;
    localparam state_t ST_MOVE  = 3'd3;
    localparam state_t ST_OVER  = 3'd4;

    // Opposite directions differ only in the upper code bit.
    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        return dir ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: one cell step in a direction plus wall check.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W   = GRID_W_DEF,
    parameter int unsigned GRID_H   = GRID_H_DEF,
    parameter int unsigned POS_BITS = POS_BITS_DEF
) (
    input  logic [6:0]          head_x,
    input  logic [6:0]          head_y,
    input  logic [POS_BITS-1:0] head_pos,
    input  logic [1:0]          dir,
    output logic [6:0]          next_x_c,
    output logic [6:0]          next_y_c,
    output logic [POS_BITS-1:0] next_pos_c,
    output logic                out_of_grid_c
);

    always_comb begin
        next_x_c      = head_x;
        next_y_c      = head_y;
        next_pos_c    = head_pos;
        out_of_grid_c = 1'b0;
        case (dir)
            DIR_UP: begin
                out_of_grid_c = (head_y == 7'd0);
                next_y_c      = head_y - 7'd1;
                next_pos_c    = head_pos - POS_BITS'(GRID_W);
            end
            DIR_DOWN: begin
                out_of_grid_c = (head_y == 7'(GRID_H - 1));
                next_y_c      = head_y + 7'd1;
                next_pos_c    = head_pos + POS_BITS'(GRID_W);
            end
            DIR_LEFT: begin
                out_of_grid_c = (head_x == 7'd0);
                next_x_c      = head_x - 7'd1;
                next_pos_c    = head_pos - POS_BITS'(1);
            end
            default: begin
                out_of_grid_c = (head_x == 7'(GRID_W - 1));
                next_x_c      = head_x + 7'd1;
                next_pos_c    = head_pos + POS_BITS'(1);
            end
        endcase
    end

endmodule

// File: rtl/snake_motion_engine.sv
// Game-step engine: owns head, body, length and direction; advances one cell per tick.
module snake_motion_engine
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
    parameter int unsigned POS_BITS = POS_BITS_DEF,
    parameter int unsigned GRID_W   = GRID_W_DEF,
    parameter int unsigned GRID_H   = GRID_H_DEF,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned START_X  = 50,
    parameter int unsigned START_Y  = 37
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         tick,
    input  logic [1:0]                   dir_req,
    input  logic                         dir_valid,
    input  logic                         food_eaten,
    input  logic                         collision,
    output logic [POS_BITS-1:0]          snake_head,
    output logic [MAX_LEN*POS_BITS-1:0]  snake_body_flat,
    output logic [6:0]                   snake_length,
    output logic [1:0]                   direction_out,
    output logic                         game_over,
    output logic                         step_done,
    output logic                         eat_pulse
);

    localparam logic [POS_BITS-1:0] START_POS = POS_BITS'(START_Y * GRID_W + START_X);
    localparam logic [6:0]          MAX_LEN_L = 7'(MAX_LEN);

    state_t                state;
    state_t                state_nxt;
    logic [6:0]            head_x;
    logic [6:0]            head_y;
    logic [6:0]            next_x;
    logic [6:0]            next_y;
    logic [POS_BITS-1:0]   next_pos;
    logic                  out_of_grid;
    logic [POS_BITS-1:0]   body [MAX_LEN];
    logic [6:0]            new_len;
    logic [1:0]            pending_dir;
    logic [1:0]            dir_sel;
    logic                  dir_ok;
    logic                  load_init;
    logic                  commit_dir;
    logic                  do_move;

    snake_next_head #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .POS_BITS (POS_BITS)
    ) u_next_head (
        .head_x        (head_x),
        .head_y        (head_y),
        .head_pos      (snake_head),
        .dir           (direction_out),
        .next_x_c      (next_x),
        .next_y_c      (next_y),
        .next_pos_c    (next_pos),
        .out_of_grid_c (out_of_grid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and the one-cycle datapath strobes.
    always_comb begin
        state_nxt  = state;
        load_init  = 1'b0;
        commit_dir = 1'b0;
        do_move    = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (tick) begin
                    state_nxt  = ST_CHECK;
                    commit_dir = 1'b1;
                end
            end
            ST_CHECK: begin
                if (collision || out_of_grid) begin
                    state_nxt = ST_OVER;
                end else begin
                    state_nxt = ST_MOVE;
                    do_move   = 1'b1;
                end
            end
            ST_MOVE: state_nxt = ST_RUN;
            ST_OVER: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    load_init = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A same-cycle legal request overrides the stored pending direction.
    always_comb begin
        dir_ok  = dir_valid && (state != ST_OVER) && (dir_req != opposite_dir(direction_out));
        dir_sel = dir_ok ? dir_req : pending_dir;
        new_len = snake_length;
        if (food_eaten && (snake_length < MAX_LEN_L)) new_len = snake_length + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || load_init) begin
            head_x        <= 7'(START_X);
            head_y        <= 7'(START_Y);
            snake_head    <= START_POS;
            snake_length  <= 7'(INIT_LEN);
            direction_out <= DIR_RIGHT;
            pending_dir   <= DIR_RIGHT;
            game_over     <= 1'b0;
            step_done     <= 1'b0;
            eat_pulse     <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                body[i] <= (i < INIT_LEN) ? START_POS - POS_BITS'(i) : '0;
            end
        end else begin
            step_done <= do_move;
            eat_pulse <= do_move && food_eaten;
            game_over <= (state_nxt == ST_OVER);
            if (dir_ok)     pending_dir   <= dir_req;
            if (commit_dir) direction_out <= dir_sel;
            if (do_move) begin
                head_x       <= next_x;
                head_y       <= next_y;
                snake_head   <= next_pos;
                snake_length <= new_len;
                body[0]      <= next_pos;
                for (int i = 1; i < int'(MAX_LEN); i++) begin
                    body[i] <= (7'(i) < new_len) ? body[i-1] : '0;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(MAX_LEN); g++) begin : g_flat
        assign snake_body_flat[g*POS_BITS +: POS_BITS] = body[g];
    end

endmodule

// File: tb/tb_snake_motion_engine.sv
// Randomized self-checking bench for snake_motion_engine against a queue-based game model.
module tb_snake_motion_engine;

    localparam int MAXL = 8;
    localparam int PB   = 13;
    localparam int GW   = 100;
    localparam int GH   = 75;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            tick = 1'b0;
    logic [1:0]      dir_req = 2'b00;
    logic            dir_valid = 1'b0;
    logic            food_eaten = 1'b0;
    logic            collision = 1'b0;
    logic [PB-1:0]   snake_head;
    logic [MAXL*PB-1:0] snake_body_flat;
    logic [6:0]      snake_length;
    logic [1:0]      direction_out;
    logic            game_over;
    logic            step_done;
    logic            eat_pulse;

    int n_vec = 0;
    int n_bad = 0;

    // Model: head coordinates, body as a queue (front = head), directions, over flag.
    int         mx, my;
    int         mq[$];
    logic [1:0] mdir, mpend;
    bit         mover;

    snake_motion_engine #(
        .MAX_LEN  (MAXL),
        .POS_BITS (PB),
        .GRID_W   (GW),
        .GRID_H   (GH),
        .INIT_LEN (3),
        .START_X  (50),
        .START_Y  (37)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .tick            (tick),
        .dir_req         (dir_req),
        .dir_valid       (dir_valid),
        .food_eaten      (food_eaten),
        .collision       (collision),
        .snake_head      (snake_head),
        .snake_body_flat (snake_body_flat),
        .snake_length    (snake_length),
        .direction_out   (direction_out),
        .game_over       (game_over),
        .step_done       (step_done),
        .eat_pulse       (eat_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic init_model(input bit reset_pending);
        mx = 50; my = 37;
        mq.delete();
        for (int i = 0; i < 3; i++) mq.push_back(my * GW + mx - i);
        mdir  = 2'b01;
        if (reset_pending) mpend = 2'b01;
        mover = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [PB-1:0] ent;
        chk({tag, ".head"}, 32'(snake_head), 32'(my * GW + mx));
        chk({tag, ".len"}, 32'(snake_length), 32'(mq.size()));
        chk({tag, ".dir"}, 32'(direction_out), 32'(mdir));
        chk({tag, ".over"}, 32'(game_over), 32'(mover));
        for (int i = 0; i < MAXL; i++) begin
            ent = snake_body_flat[i*PB +: PB];
            chk($sformatf("%s.body%0d", tag, i), 32'(ent), (i < mq.size()) ? 32'(mq[i]) : 32'd0);
        end
    endtask

    // Model effect of the direction request sampled at the edge just taken.
    task automatic apply_dir();
        if (dir_valid && !mover && (dir_req != (mdir ^ 2'b10))) mpend = dir_req;
    endtask

    task automatic drive_dir();
        dir_valid = ($urandom_range(0, 2) == 0);
        dir_req   = 2'($urandom_range(0, 3));
    endtask

    task automatic model_move(input bit food, input bit col);
        int nx, ny, nl;
        nx = mx; ny = my;
        case (mdir)
            2'b00: ny = ny - 1;
            2'b01: nx = nx + 1;
            2'b10: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        if (col || nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            mover = 1'b1;
        end else begin
            mx = nx; my = ny;
            nl = mq.size() + (food ? 1 : 0);
            if (nl > MAXL) nl = MAXL;
            mq.push_front(ny * GW + nx);
            while (mq.size() > nl) void'(mq.pop_back());
        end
    endtask

    task automatic step(input bit dv, input logic [1:0] d, input bit food, input bit col, input bit noise);
        tick = 1'b1; dir_valid = dv; dir_req = d;
        @(posedge clk); apply_dir(); mdir = mpend; #1;
        chk("commit.dir", 32'(direction_out), 32'(mdir));
        chk("commit.step_done", 32'(step_done), 32'd0);
        tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) drive_dir(); else dir_valid = 1'b0;
        food_eaten = food; collision = col;
        @(posedge clk); apply_dir(); model_move(food, col); #1;
        food_eaten = 1'b0; collision = 1'b0;
        check_all("move");
        chk("move.step_done", 32'(step_done), 32'(!mover));
        chk("move.eat", 32'(eat_pulse), 32'(!mover && food));
        tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) drive_dir(); else dir_valid = 1'b0;
        @(posedge clk); apply_dir(); #1;
        tick = 1'b0; dir_valid = 1'b0;
        chk("after.step_done", 32'(step_done), 32'd0);
        chk("after.eat", 32'(eat_pulse), 32'd0);
        chk("after.over", 32'(game_over), 32'(mover));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive_dir();
            @(posedge clk); apply_dir(); #1;
            chk("idle.step_done", 32'(step_done), 32'd0);
        end
        dir_valid = 1'b0;
    endtask

    task automatic over_hold(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; drive_dir();
            @(posedge clk); apply_dir(); #1;
            check_all("over");
            chk("over.step_done", 32'(step_done), 32'd0);
        end
        tick = 1'b0; dir_valid = 1'b0;
    endtask

    task automatic restart(input bit from_over);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (from_over) init_model(1'b1);
        check_all("start");
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; start = 1'b0; dir_valid = 1'b0;
        food_eaten = 1'b0; collision = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        init_model(1'b1);
        check_all("reset");
        chk("reset.step_done", 32'(step_done), 32'd0);
        chk("reset.eat", 32'(eat_pulse), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        restart(1'b0);

        // First step, reversal, eat, turn.
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("first.head", 32'(snake_head), 32'd3751);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

        // Grow to saturation and beyond.
        for (int k = 0; k < 7; k++) step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Collision, ticks ignored, restart.
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        over_hold(3);
        restart(1'b1);

        // Walk into the top wall.
        for (int k = 0; k < 38; k++) step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        over_hold(2);
        restart(1'b1);

        // Walk into the right wall.
        for (int k = 0; k < 50; k++) step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        over_hold(2);
        restart(1'b1);

        // Reset while CHECK is active; ticks in IDLE must do nothing.
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick = 1'b1;
        @(posedge clk); apply_dir(); mdir = mpend; #1;
        tick = 1'b0; rst = 1'b1; food_eaten = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; food_eaten = 1'b0;
        init_model(1'b1);
        check_all("rst_check");
        chk("rst_check.step_done", 32'(step_done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick = 1'b1;
            @(posedge clk); #1;
            chk("idle_tick.step_done", 32'(step_done), 32'd0);
            chk("idle_tick.head", 32'(snake_head), 32'd3750);
        end
        tick = 1'b0;
        restart(1'b0);

        // Randomized play.
        for (int k = 0; k < 150; k++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0), 1'b1);
            if (mover) begin
                over_hold(2);
                restart(1'b1);
            end else begin
                idle($urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
